// File: rtl/student_fir_pkg.sv
// Shared definitions for the student FIR chain: default word widths, the requantisation shift
// and the narrowing saturator used by the FIR stages.
package student_fir_pkg;

  localparam int FIR_OUT_W     = 32;
  localparam int SAMPLE_W      = 16;
  localparam int REQUANT_SHIFT = 15;

  // Returns 1 when the value had to be clamped; narrow receives the clamped or truncated sample.
  function automatic logic sat_narrow(input  logic signed [FIR_OUT_W:0] wide,
                                      output logic [SAMPLE_W-1:0]       narrow);
    logic [FIR_OUT_W-SAMPLE_W+1:0] hi;
    hi = wide[FIR_OUT_W:SAMPLE_W-1];
    if ((hi == '0) || (hi == '1)) begin
      narrow = wide[SAMPLE_W-1:0];
      return 1'b0;
    end
    narrow = wide[FIR_OUT_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    return 1'b1;
  endfunction

endpackage

// File: rtl/student_sync_fifo.sv
// Single-clock FIFO with registered first-word-fall-through head; the head holds its last
// value once the FIFO drains.
module student_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_FULL);
  assign head_o  = head_q;
  assign level_o = level_q;
  assign rd_next = rd_ptr_q + 1'b1;

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_next;
    if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
    else if (!do_push && do_pop) level_d = level_q - LVL_ONE;
    if (do_pop) begin
      if (level_q > LVL_ONE) head_d = mem_q[rd_next];
      else if (do_push)      head_d = wdata_i;
    end else if (empty_o && do_push) begin
      head_d = wdata_i;
    end
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      head_d   = head_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/student_fir_requant.sv
// Captures the FIR accumulator on each strobe rising edge, rounds half-up, shifts, saturates
// to the sample width and queues the result behind a valid/ready output with status counters.
module student_fir_requant
  import student_fir_pkg::*;
#(
  parameter int DATA_SIZE_FIR_OUT = FIR_OUT_W,
  parameter int DATA_SIZE         = SAMPLE_W,
  parameter int SHIFT             = REQUANT_SHIFT,
  parameter int FIFO_DEPTH        = 4,
  parameter int SAT_CNT_WIDTH     = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            valid_strobe_in,
  input  logic [DATA_SIZE_FIR_OUT-1:0]    y_in,
  input  logic                            clear_i,
  output logic [DATA_SIZE-1:0]            sample_o,
  output logic                            sample_valid_o,
  input  logic                            sample_ready_i,
  output logic                            overflow_o,
  output logic [SAT_CNT_WIDTH-1:0]        sat_count_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

  localparam int W = DATA_SIZE_FIR_OUT;
  localparam logic [W:0] ROUND_C =
    (SHIFT == 0) ? '0 : ((W+1)'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));

  logic                     strobe_prev_q;
  logic                     edge_det;
  logic                     v1_q, v1_d;
  logic signed [W:0]        r_q, r_d;
  logic signed [W:0]        s_full;
  logic [W-DATA_SIZE+1:0]   s_hi;
  logic                     sat_pos, sat_neg, sat_any;
  logic [DATA_SIZE-1:0]     result;
  logic                     push, fifo_empty, fifo_full, pop_now;
  logic                     overflow_q, overflow_d;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q, sat_cnt_d;

  assign edge_det = valid_strobe_in & ~strobe_prev_q;

  // Stage 1: the extra top bit keeps the rounding add from wrapping at the positive limit.
  always_comb begin
    v1_d = edge_det & ~clear_i;
    r_d  = r_q;
    if (edge_det) r_d = $signed({y_in[W-1], y_in}) + $signed(ROUND_C);
  end

  // Stage 2: everything above the sample's sign bit must be pure sign extension to fit.
  assign s_full  = r_q >>> SHIFT;
  assign s_hi    = s_full[W:DATA_SIZE-1];
  assign sat_any = ~((s_hi == '0) || (s_hi == '1));
  assign sat_pos = sat_any & ~s_full[W];
  assign sat_neg = sat_any &  s_full[W];

  always_comb begin
    result = s_full[DATA_SIZE-1:0];
    if (sat_pos)      result = {1'b0, {(DATA_SIZE-1){1'b1}}};
    else if (sat_neg) result = {1'b1, {(DATA_SIZE-1){1'b0}}};
  end

  assign push    = v1_q & ~clear_i;
  assign pop_now = sample_ready_i & ~fifo_empty;

  always_comb begin
    overflow_d = overflow_q;
    sat_cnt_d  = sat_cnt_q;
    if (clear_i) begin
      overflow_d = 1'b0;
      sat_cnt_d  = '0;
    end else begin
      if (push && fifo_full && !pop_now) overflow_d = 1'b1;
      if (push && sat_any && !(&sat_cnt_q)) sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strobe_prev_q <= 1'b0;
      v1_q          <= 1'b0;
      r_q           <= '0;
      overflow_q    <= 1'b0;
      sat_cnt_q     <= '0;
    end else begin
      strobe_prev_q <= valid_strobe_in;
      v1_q          <= v1_d;
      r_q           <= r_d;
      overflow_q    <= overflow_d;
      sat_cnt_q     <= sat_cnt_d;
    end
  end

  student_sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .wdata_i (result),
    .pop_i   (sample_ready_i),
    .head_o  (sample_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level_o)
  );

  assign sample_valid_o = ~fifo_empty;
  assign overflow_o     = overflow_q;
  assign sat_count_o    = sat_cnt_q;

endmodule

// File: tb/tb_student_fir_requant.sv
// Directed bench for student_fir_requant: table of requantisation vectors plus hand-written
// sequences for strobe hold, FIFO full/overflow, clear and asynchronous reset.
module tb_student_fir_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_strobe_in;
  logic [31:0] y_in;
  logic        clear_i;
  logic [15:0] sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic        overflow_o;
  logic [15:0] sat_count_o;
  logic [2:0]  fifo_level_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] y;
    logic [15:0] exp_s;
    logic [15:0] exp_sat;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  student_fir_requant #(
    .DATA_SIZE_FIR_OUT (32),
    .DATA_SIZE         (16),
    .SHIFT             (15),
    .FIFO_DEPTH        (4),
    .SAT_CNT_WIDTH     (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .valid_strobe_in (valid_strobe_in),
    .y_in            (y_in),
    .clear_i         (clear_i),
    .sample_o        (sample_o),
    .sample_valid_o  (sample_valid_o),
    .sample_ready_i  (sample_ready_i),
    .overflow_o      (overflow_o),
    .sat_count_o     (sat_count_o),
    .fifo_level_o    (fifo_level_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single edge with ready=1 on an empty FIFO; checks the two-cycle latency and the value.
  task automatic apply_vec(input logic [31:0] y, input logic [15:0] exp_s,
                           input logic [15:0] exp_sat, input string name);
    y_in = y;
    valid_strobe_in = 1'b1;
    step();
    valid_strobe_in = 1'b0;
    @(negedge clk);
    check({name, " valid@N+1"}, 32'(sample_valid_o), 32'd0);
    step();
    @(negedge clk);
    check({name, " valid@N+2"}, 32'(sample_valid_o), 32'd1);
    check({name, " sample"}, 32'(sample_o), 32'(exp_s));
    check({name, " sat_count"}, 32'(sat_count_o), 32'(exp_sat));
    step();
  endtask

  task automatic pulse(input logic [31:0] y);
    y_in = y;
    valid_strobe_in = 1'b1;
    step();
    valid_strobe_in = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_4000, 16'h0001, 16'd0};
    vecs[1] = '{32'h0000_3FFF, 16'h0000, 16'd0};
    vecs[2] = '{32'hFFFF_C000, 16'h0000, 16'd0};
    vecs[3] = '{32'hFFFF_BFFF, 16'hFFFF, 16'd0};
    vecs[4] = '{32'h3FFF_8000, 16'h7FFF, 16'd0};
    vecs[5] = '{32'hC000_0000, 16'h8000, 16'd0};
    vecs[6] = '{32'h3FFF_C000, 16'h7FFF, 16'd1};
    vecs[7] = '{32'hBFFF_BFFF, 16'h8000, 16'd2};
    vecs[8] = '{32'h7FFF_FFFF, 16'h7FFF, 16'd3};
    vecs[9] = '{32'h8000_0000, 16'h8000, 16'd4};

    rst = 1'b1;
    valid_strobe_in = 1'b0;
    y_in = '0;
    clear_i = 1'b0;
    sample_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset sample", 32'(sample_o), 32'd0);
    check("reset valid", 32'(sample_valid_o), 32'd0);
    check("reset overflow", 32'(overflow_o), 32'd0);
    check("reset sat", 32'(sat_count_o), 32'd0);
    check("reset level", 32'(fifo_level_o), 32'd0);
    rst = 1'b0;
    step();

    sample_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i].y, vecs[i].exp_s, vecs[i].exp_sat, $sformatf("vec%0d", i));
    end

    // Saturation count restarts after clear.
    do_clear();
    @(negedge clk);
    check("clear sat", 32'(sat_count_o), 32'd0);
    check("clear level", 32'(fifo_level_o), 32'd0);
    step();
    apply_vec(32'h7FFF_FFFF, 16'h7FFF, 16'd1, "sat_pos");
    apply_vec(32'h8000_0000, 16'h8000, 16'd2, "sat_neg");

    // Strobe held high for 10 cycles gives one capture.
    sample_ready_i = 1'b0;
    y_in = 32'h0001_0000;
    valid_strobe_in = 1'b1;
    repeat (10) step();
    valid_strobe_in = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("hold level", 32'(fifo_level_o), 32'd1);
    check("hold sample", 32'(sample_o), 32'h0002);
    sample_ready_i = 1'b1;
    step();
    sample_ready_i = 1'b0;
    @(negedge clk);
    check("hold drained", 32'(fifo_level_o), 32'd0);
    check("hold sample kept", 32'(sample_o), 32'h0002);
    step();

    // Overflow: fifth sample dropped while the FIFO is full.
    for (int k = 1; k <= 5; k++) pulse(32'(k) << 15);
    step();
    @(negedge clk);
    check("ovf level", 32'(fifo_level_o), 32'd4);
    check("ovf flag", 32'(overflow_o), 32'd1);
    step();
    sample_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("ovf pop%0d", k), 32'(sample_o), 32'(k));
      step();
    end
    @(negedge clk);
    check("ovf empty", 32'(sample_valid_o), 32'd0);
    check("ovf sample kept", 32'(sample_o), 32'd4);
    sample_ready_i = 1'b0;
    step();

    // Full FIFO with a pop coinciding with the push.
    do_clear();
    @(negedge clk);
    check("clear overflow", 32'(overflow_o), 32'd0);
    step();
    for (int k = 11; k <= 14; k++) pulse(32'(k) << 15);
    @(negedge clk);
    check("full level", 32'(fifo_level_o), 32'd4);
    step();
    y_in = 32'd15 << 15;
    valid_strobe_in = 1'b1;
    step();
    valid_strobe_in = 1'b0;
    sample_ready_i = 1'b1;
    step();
    sample_ready_i = 1'b0;
    @(negedge clk);
    check("pp level", 32'(fifo_level_o), 32'd4);
    check("pp overflow", 32'(overflow_o), 32'd0);
    step();
    sample_ready_i = 1'b1;
    for (int k = 12; k <= 15; k++) begin
      @(negedge clk);
      check($sformatf("pp pop%0d", k), 32'(sample_o), 32'(k));
      step();
    end
    @(negedge clk);
    check("pp empty", 32'(fifo_level_o), 32'd0);
    step();

    // Edge coinciding with clear, and clear while the sample is in flight.
    y_in = 32'h0000_8000;
    valid_strobe_in = 1'b1;
    clear_i = 1'b1;
    step();
    valid_strobe_in = 1'b0;
    clear_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("clr edge level", 32'(fifo_level_o), 32'd0);
    step();
    valid_strobe_in = 1'b1;
    step();
    valid_strobe_in = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("clr flight valid", 32'(sample_valid_o), 32'd0);
    step();

    // Asynchronous reset in the middle of stage 2 with two entries queued.
    sample_ready_i = 1'b0;
    pulse(32'h7FFF_FFFF);
    pulse(32'h0000_8000);
    @(negedge clk);
    check("pre-rst level", 32'(fifo_level_o), 32'd2);
    check("pre-rst sat", 32'(sat_count_o), 32'd1);
    step();
    y_in = 32'h0001_0000;
    valid_strobe_in = 1'b1;
    step();
    valid_strobe_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst sample", 32'(sample_o), 32'd0);
    check("rst valid", 32'(sample_valid_o), 32'd0);
    check("rst overflow", 32'(overflow_o), 32'd0);
    check("rst sat", 32'(sat_count_o), 32'd0);
    check("rst level", 32'(fifo_level_o), 32'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check("post-rst level", 32'(fifo_level_o), 32'd0);
    step();
    sample_ready_i = 1'b1;
    apply_vec(32'h0000_8000, 16'h0001, 16'd0, "post-rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/student_fir_requant.md
Name: student_fir_requant

Overview:
Downstream stage of the FIR core. It captures the wide accumulator result (y_out with valid_strobe_out) on each rising edge of the strobe, then round-shifts and saturates it to a DATA_SIZE signed sample. Results are buffered in a small synchronous FIFO behind a valid/ready interface that feeds the audio output path. Saturation and overflow events are reported as status for software and debug.

Parameters:
DATA_SIZE_FIR_OUT, 32, width of the incoming accumulator word, two's complement.
DATA_SIZE, 16, width of the output sample, two's complement.
SHIFT, 15, arithmetic right shift applied after rounding. Range 0..DATA_SIZE_FIR_OUT-1.
FIFO_DEPTH, 4, output buffer entries. Power of two, at least 2.
SAT_CNT_WIDTH, 16, width of the saturation event counter.

Ports:
clk_i  in  1  system clock; one clock domain only.
rst_i  in  1  reset, asynchronous and active-high.
valid_strobe_in  in  1  level strobe from the FIR core; only its rising edge is significant.
y_in  in  DATA_SIZE_FIR_OUT  FIR accumulator result; sampled in the edge cycle.
clear_i  in  1  synchronous clear of the FIFO, overflow_o and sat_count_o.
sample_o  out  DATA_SIZE  FIFO head sample.
sample_valid_o  out  1  FIFO non-empty.
sample_ready_i  in  1  consumer accepts the head entry when it is high together with sample_valid_o.
overflow_o  out  1  sticky flag: a result was dropped because the FIFO was full.
sat_count_o  out  SAT_CNT_WIDTH  number of saturated results; sticks at the all-ones value.
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, synchronous deassert assumed at top level): all outputs 0, FIFO empty, pipeline valid bits 0, edge-detect history 0.
- Edge detect: edge = valid_strobe_in & ~strobe_prev. strobe_prev is registered every cycle. A strobe held high yields exactly one capture.
- Stage 1, at the clock after the edge cycle: register r = y_in + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed at DATA_SIZE_FIR_OUT+1 bits signed so the addition cannot wrap. Set v1.
- Stage 2, next clock: s = r >>> SHIFT (arithmetic).
  - If s > 2^(DATA_SIZE-1)-1, output 0x7FFF.
  - If s < -2^(DATA_SIZE-1), output 0x8000.
  - Otherwise output s truncated to DATA_SIZE.
  - Push the result to the FIFO. If it was clamped, increment sat_count_o, saturating at the maximum value.
- Latency: edge detected in cycle N; sample visible with sample_valid_o=1 in cycle N+2 when the FIFO was empty.
- Rounding is round-half-up (toward +inf): -0.5 LSB rounds to 0, +0.5 LSB rounds to +1.
- FIFO:
  - Pop when sample_valid_o & sample_ready_i.
  - Push when stage 2 completes.
  - Push and pop in the same cycle when full: both happen, level stays at FIFO_DEPTH, no overflow.
  - Push when full with no pop: the new sample is dropped, FIFO contents are unchanged, and overflow_o sets at the next clock.
  - Pointers wrap modulo FIFO_DEPTH. Head data is registered, first-word-fall-through.
- sample_o holds its last value when empty. It must not be consumed while sample_valid_o=0.
- clear_i: the next clock empties the FIFO and clears overflow_o and sat_count_o. Stage 1/2 contents in flight are discarded. An edge that coincides with clear_i is also discarded.
- Back-to-back strobes: the pipeline accepts one edge per 2 cycles (the edge detect needs a low cycle). No stall is required.
- rst_i mid-operation: everything returns immediately to reset values and in-flight samples are lost.

Decomposition:
- Package student_fir_pkg holds:
  - localparams FIR_OUT_W=32, SAMPLE_W=16, REQUANT_SHIFT=15.
  - function sat_narrow(input wide, output narrow) shared with the other FIR stages.
- Sub-module student_sync_fifo (params WIDTH, DEPTH) provides push/pop, full/empty, level and first-word-fall-through head. Reused elsewhere.

Test Plan:
1. SHIFT=15; edges with y_in = 0x00004000, 0x00003FFF, 0xFFFFC000 (ready=1) -> sample_o = 0x0001, 0x0000, 0x0000; sat_count 0; sample_valid_o appears exactly 2 cycles after each edge cycle.
2. y_in = 0x7FFFFFFF, then 0x80000000 -> sample_o = 0x7FFF then 0x8000; sat_count_o = 2.
3. valid_strobe_in held high 10 cycles with y_in=0x00010000 -> exactly one FIFO entry, 0x0002; fifo_level_o=1.
4. sample_ready_i=0; 5 edges with y_in = k<<15 for k=1..5 -> fifo_level_o=4, overflow_o=1; then ready=1 -> pops 1,2,3,4 in order, 5 never appears.
5. FIFO full while ready pulses for one cycle coincident with a push -> level stays 4, overflow_o stays 0, order preserved.
6. rst_i asserted asynchronously mid-stage-2 with 2 entries queued -> all outputs 0 before the next clock edge; after release, a new edge with y_in=0x00008000 yields 0x0001.
